// File: rtl/ram_scan_ctrl_pkg.sv
// Shared types and default parameters for the RAM scan controller.
package ram_scan_ctrl_pkg;

  localparam int unsigned DefDataW   = 8;
  localparam int unsigned DefAddrW   = 5;
  localparam int unsigned DefTickDiv = 50_000_000;

  typedef enum logic [1:0] {
    StScan     = 2'd0,
    StWrite    = 2'd1,
    StReadback = 2'd2
  } state_e;

endpackage

// File: rtl/ram_scan_ctrl_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clock cycles.
module tick_gen
  import ram_scan_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = DefTickDiv
) (
  input  logic CLOCK_50,
  input  logic RST,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/ram_scan_ctrl.sv
// Scans a small RAM on a slow tick and shows each word; edge-triggered writes
// interrupt the scan for a write cycle and a read-back cycle.
module ram_scan_ctrl
  import ram_scan_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned TICK_DIV = DefTickDiv
) (
  input  logic              CLOCK_50,
  input  logic              RST,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic              sel_addr,
  input  logic              load,
  input  logic              wr_en,
  input  logic              hold,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] wr_addr_q,
  output logic              busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic              tick, scan_tick, wr_rise;
  logic              wr_en_prev_q;
  logic              wr_pend_q, wr_pend_d;
  logic              tick_pend_q, tick_pend_d;
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] snap_addr_q, snap_addr_d;
  logic [DATA_W-1:0] snap_data_q, snap_data_d;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata_q;
  logic              rd_pipe_vld_q;
  logic [ADDR_W-1:0] rd_pipe_addr_q;
  logic [DATA_W-1:0] mem_q [Depth];

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .CLOCK_50(CLOCK_50),
    .RST     (RST),
    .tick    (tick)
  );

  assign wr_rise   = wr_en & ~wr_en_prev_q;
  assign scan_tick = tick & ~hold;
  assign busy      = (state_q != StScan);

  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      state_q <= StScan;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_pend_d   = wr_pend_q;
    tick_pend_d = tick_pend_q;
    scan_addr_d = scan_addr_q;
    snap_addr_d = snap_addr_q;
    snap_data_d = snap_data_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_raddr   = scan_addr_q;
    unique case (state_q)
      StScan: begin
        // A write outranks any tick; the tick waits as the single pending one.
        if (wr_pend_q || wr_rise) begin
          state_d     = StWrite;
          wr_pend_d   = 1'b0;
          snap_addr_d = wr_addr_q;
          snap_data_d = data_q;
          if (scan_tick) tick_pend_d = 1'b1;
        end else if (!hold && (tick || tick_pend_q)) begin
          ram_re      = 1'b1;
          scan_addr_d = scan_addr_q + 1'b1;
          tick_pend_d = 1'b0;
        end
      end
      StWrite: begin
        ram_we  = 1'b1;
        state_d = StReadback;
        if (wr_rise)   wr_pend_d   = 1'b1;
        if (scan_tick) tick_pend_d = 1'b1;
      end
      StReadback: begin
        ram_re    = 1'b1;
        ram_raddr = snap_addr_q;
        state_d   = StScan;
        if (wr_rise)   wr_pend_d   = 1'b1;
        if (scan_tick) tick_pend_d = 1'b1;
      end
      default: state_d = StScan;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      wr_en_prev_q   <= 1'b0;
      wr_pend_q      <= 1'b0;
      tick_pend_q    <= 1'b0;
      scan_addr_q    <= '0;
      wr_addr_q      <= '0;
      data_q         <= '0;
      snap_addr_q    <= '0;
      snap_data_q    <= '0;
      rd_pipe_vld_q  <= 1'b0;
      rd_pipe_addr_q <= '0;
      rd_data        <= '0;
      rd_addr        <= '0;
      rd_valid       <= 1'b0;
    end else begin
      wr_en_prev_q   <= wr_en;
      wr_pend_q      <= wr_pend_d;
      tick_pend_q    <= tick_pend_d;
      scan_addr_q    <= scan_addr_d;
      snap_addr_q    <= snap_addr_d;
      snap_data_q    <= snap_data_d;
      if (load && sel_addr)  wr_addr_q <= sw_addr;
      if (load && !sel_addr) data_q    <= sw_data;
      rd_pipe_vld_q  <= ram_re;
      rd_pipe_addr_q <= ram_raddr;
      rd_valid       <= rd_pipe_vld_q;
      // Address travels with its read so the displayed pair always matches.
      if (rd_pipe_vld_q) begin
        rd_data <= ram_rdata_q;
        rd_addr <= rd_pipe_addr_q;
      end
    end
  end

  // RAM array and its read register are deliberately left out of reset.
  always_ff @(posedge CLOCK_50) begin
    if (ram_we) mem_q[snap_addr_q] <= snap_data_q;
    if (ram_re) ram_rdata_q <= mem_q[ram_raddr];
  end

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Self-checking bench for ram_scan_ctrl: directed scenarios plus random traffic,
// all compared every cycle against a transaction-level model.
module tb_ram_scan_ctrl;

  localparam int TD    = 4;
  localparam int Depth = 32;

  logic       CLOCK_50 = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] sw_data = '0;
  logic [4:0] sw_addr = '0;
  logic       sel_addr = 1'b0, load = 1'b0, wr_en = 1'b0, hold = 1'b0;
  logic [7:0] rd_data;
  logic [4:0] rd_addr, wr_addr_q;
  logic       rd_valid, busy;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  ram_scan_ctrl #(
    .DATA_W  (8),
    .ADDR_W  (5),
    .TICK_DIV(TD)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .sw_data  (sw_data),
    .sw_addr  (sw_addr),
    .sel_addr (sel_addr),
    .load     (load),
    .wr_en    (wr_en),
    .hold     (hold),
    .rd_data  (rd_data),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .wr_addr_q(wr_addr_q),
    .busy     (busy)
  );

  // ---------------- reference model ----------------
  typedef struct {int due; int a; logic [7:0] d; bit k;} res_t;
  res_t       m_q[$];
  res_t       m_r;
  logic [7:0] m_mem[Depth];
  bit         m_known[Depth];
  int         m_since, m_edge, m_busy_left, m_scan, m_addr_reg, m_snap_a;
  logic [7:0] m_data_reg, m_snap_d;
  bit         m_wr_prev, m_wr_pend, m_tick_pend, m_tick, m_rise, m_stick;
  logic [7:0] e_data;
  int         e_addr;
  bit         e_valid, e_known;

  task m_reset();
    m_since = 0; m_busy_left = 0; m_scan = 0; m_addr_reg = 0; m_snap_a = 0;
    m_data_reg = 0; m_snap_d = 0; m_wr_prev = 0; m_wr_pend = 0; m_tick_pend = 0;
    m_q.delete();
    e_data = 0; e_addr = 0; e_valid = 0; e_known = 1;
  endtask

  // A read started in one cycle is on the outputs two cycles later.
  task m_issue(input int a);
    m_q.push_back('{due: m_edge + 1, a: a, d: m_mem[a], k: m_known[a]});
  endtask

  always @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      m_reset();
    end else begin
      m_tick  = (m_since % TD) == TD - 1;
      m_rise  = wr_en && !m_wr_prev;
      m_stick = m_tick && !hold;
      m_edge++;
      e_valid = 0;
      while (m_q.size() > 0 && m_q[0].due == m_edge) begin
        m_r = m_q.pop_front();
        e_valid = 1; e_addr = m_r.a; e_data = m_r.d; e_known = m_r.k;
      end
      if (m_busy_left == 0) begin
        if (m_wr_pend || m_rise) begin
          m_snap_a = m_addr_reg; m_snap_d = m_data_reg; m_wr_pend = 0;
          if (m_stick) m_tick_pend = 1;
          m_busy_left = 2;
        end else if (!hold && (m_tick || m_tick_pend)) begin
          m_issue(m_scan);
          m_scan = (m_scan + 1) % Depth;
          m_tick_pend = 0;
        end
      end else begin
        if (m_rise) m_wr_pend = 1;
        if (m_stick) m_tick_pend = 1;
        if (m_busy_left == 2) begin
          m_mem[m_snap_a] = m_snap_d;
          m_known[m_snap_a] = 1;
        end else begin
          m_issue(m_snap_a);
        end
        m_busy_left--;
      end
      if (load && sel_addr) m_addr_reg = int'(sw_addr);
      if (load && !sel_addr) m_data_reg = sw_data;
      m_wr_prev = wr_en;
      m_since++;
    end
  end

  // ---------------- checking ----------------
  task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      chk("model rd_valid", rd_valid, e_valid);
      chk("model rd_addr", rd_addr, e_addr);
      if (e_known) chk("model rd_data", rd_data, e_data);
      chk("model busy", busy, m_busy_left != 0);
      chk("model wr_addr_q", wr_addr_q, m_addr_reg);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic load_reg(input bit sa, input logic [7:0] v);
    sel_addr = sa;
    if (sa) sw_addr = v[4:0];
    else sw_data = v;
    load = 1;
    cyc(1);
    load = 0;
  endtask

  // Returns at the falling edge where a matching result is shown (a < 0: any).
  task automatic wait_valid(input int a, input int budget, output bit found);
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge CLOCK_50);
      if (rd_valid === 1'b1 && (a < 0 || int'(rd_addr) == a)) found = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit f, bprev;
    int n, last, rises;
    #2;
    RST = 0;
    chk_en = 1;
    cyc(2);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset rd_addr", rd_addr, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset busy", busy, 0);
    chk("reset wr_addr_q", wr_addr_q, 0);
    RST = 1;

    // Full scan wraps back to 0.
    for (int i = 0; i < 33; i++) begin
      wait_valid(-1, 12, f);
      if (!f) chk("scan wait", f, 1);
      else chk("scan order", rd_addr, i % Depth);
    end

    // Write 0xA5 to 7 and watch the read-back.
    cyc(1);
    load_reg(1, 8'd7);
    load_reg(0, 8'hA5);
    wr_en = 1;
    cyc(1);
    wr_en = 0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy) n++;
      cyc(1);
    end
    chk("write busy cycles", n, 2);
    chk("readback valid", rd_valid, 1);
    chk("readback addr", rd_addr, 7);
    chk("readback data", rd_data, 8'hA5);
    wait_valid(7, 200, f);
    chk("scan finds 7", f, 1);
    chk("scan data at 7", rd_data, 8'hA5);

    // Held wr_en writes once; data loaded during WRITE is not used.
    cyc(1);
    load_reg(1, 8'd9);
    load_reg(0, 8'h3C);
    wr_en = 1;
    bprev = busy;
    rises = 0;
    for (int j = 0; j < 20; j++) begin
      load = (j == 1);
      sel_addr = 0;
      if (j == 1) sw_data = 8'hFF;
      cyc(1);
      if (busy && !bprev) rises++;
      bprev = busy;
    end
    load = 0;
    wr_en = 0;
    chk("held wr_en writes", rises, 1);
    wait_valid(9, 200, f);
    chk("scan finds 9", f, 1);
    chk("snapshot data at 9", rd_data, 8'h3C);

    // Write entry on a tick cycle: the tick is served right after read-back.
    wait_valid(-1, 12, f);
    last = int'(rd_addr);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (m_since % TD != TD - 1 && n < 8);
    wr_en = 1;
    cyc(1);
    wr_en = 0;
    wait_valid(9, 8, f);
    chk("coincident readback", f, 1);
    @(negedge CLOCK_50);
    chk("pending tick valid", rd_valid, 1);
    chk("pending tick addr", rd_addr, (last + 1) % Depth);

    // hold freezes the display, then scanning resumes at the next address.
    cyc(1);
    hold = 1;
    cyc(3);
    last = int'(rd_addr);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (rd_valid) n++;
      cyc(1);
    end
    chk("hold valid pulses", n, 0);
    chk("hold addr static", rd_addr, last);
    hold = 0;
    wait_valid(-1, 12, f);
    chk("resume addr", rd_addr, (last + 1) % Depth);

    // Reset mid-scan at address 19; RAM keeps its contents.
    wait_valid(18, 200, f);
    chk("scan reaches 18", f, 1);
    cyc(1);
    RST = 0;
    #1;
    chk("async reset rd_addr", rd_addr, 0);
    chk("async reset rd_data", rd_data, 0);
    chk("async reset rd_valid", rd_valid, 0);
    cyc(2);
    RST = 1;
    wait_valid(-1, 12, f);
    chk("post-reset first addr", rd_addr, 0);
    wait_valid(7, 100, f);
    chk("retained data at 7", rd_data, 8'hA5);

    // Reset during WRITE cancels the write.
    cyc(1);
    load_reg(1, 8'd7);
    load_reg(0, 8'h5A);
    wr_en = 1;
    cyc(1);
    wr_en = 0;
    RST = 0;
    #1;
    chk("reset drops busy", busy, 0);
    cyc(1);
    RST = 1;
    wait_valid(7, 200, f);
    chk("suppressed write at 7", rd_data, 8'hA5);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      RST = ($urandom_range(0, 399) != 0);
      load = ($urandom_range(0, 3) == 0);
      sel_addr = 1'($urandom_range(0, 1));
      sw_addr = 5'($urandom);
      sw_data = 8'($urandom);
      if ($urandom_range(0, 7) == 0) wr_en = ~wr_en;
      if ($urandom_range(0, 47) == 0) hold = ~hold;
      cyc(1);
    end
    RST = 1;
    load = 0;
    wr_en = 0;
    hold = 0;
    cyc(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
